// File: rtl/axis_lrelu_config_injector.sv
// axis_lrelu_config_injector
// Frames the LReLU engine input stream: for each iteration a block of config beats (1x1 or 3x3
// sized, chosen by kw2 on the first beat) followed by conv-output data beats up to tlast.
// A two-entry registered skid buffer drives the master port.
module axis_lrelu_config_injector #(
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned TUSER_WIDTH   = 8,
    parameter int unsigned I_KW2         = 0,
    parameter int unsigned BITS_KW2      = 3,
    parameter int unsigned CFG_BEATS_1X1 = 2,
    parameter int unsigned CFG_BEATS_3X3 = 10
) (
    input  logic                   aclk,
    input  logic                   areset,

    input  logic                   s_cfg_tvalid,
    output logic                   s_cfg_tready,
    input  logic [DATA_WIDTH-1:0]  s_cfg_tdata,
    input  logic [TUSER_WIDTH-1:0] s_cfg_tuser,
    input  logic                   s_cfg_tlast,

    input  logic                   s_dat_tvalid,
    output logic                   s_dat_tready,
    input  logic [DATA_WIDTH-1:0]  s_dat_tdata,
    input  logic [TUSER_WIDTH-1:0] s_dat_tuser,
    input  logic                   s_dat_tlast,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tlast,

    output logic                   cfg_error,
    output logic [1:0]             debug_state,
    output logic [15:0]            iter_count
);

    localparam int unsigned MAX_BEATS = (CFG_BEATS_3X3 > CFG_BEATS_1X1) ? CFG_BEATS_3X3
                                                                        : CFG_BEATS_1X1;
    // Counter holds remaining beats after the first, i.e. at most MAX_BEATS-1.
    localparam int unsigned CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [1:0] {
        StCfgFirst = 2'd0,
        StCfgRest  = 2'd1,
        StPass     = 2'd2
    } state_e;

    state_e                 r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic                   r_cfg_error, w_cfg_error_next;
    logic [15:0]            r_iter, w_iter_next;

    // Skid buffer: head entry drives the master port, second entry absorbs a stall.
    logic [1:0]             r_count;
    logic [DATA_WIDTH-1:0]  r_head_data, r_skid_data;
    logic [TUSER_WIDTH-1:0] r_head_user, r_skid_user;
    logic                   r_head_last, r_skid_last;

    logic                   w_pop, w_buf_ready, w_cfg_phase;
    logic                   w_cfg_hs, w_dat_hs, w_push;
    logic [DATA_WIDTH-1:0]  w_in_data;
    logic [TUSER_WIDTH-1:0] w_in_user;
    logic                   w_in_last;
    logic                   w_kw2_zero, w_nth_beat;
    logic [CNT_W-1:0]       w_first_cnt;

    assign w_pop       = (r_count != 2'd0) && m_axis_tready;
    assign w_buf_ready = (r_count != 2'd2) || w_pop;
    assign w_cfg_phase = (r_state != StPass);

    // Only one slave port is ever ready; reset holds both off.
    assign s_cfg_tready = !areset && w_cfg_phase && w_buf_ready;
    assign s_dat_tready = !areset && !w_cfg_phase && w_buf_ready;

    assign w_cfg_hs = s_cfg_tvalid && s_cfg_tready;
    assign w_dat_hs = s_dat_tvalid && s_dat_tready;
    assign w_push   = w_cfg_hs || w_dat_hs;

    assign w_kw2_zero  = (s_cfg_tuser[I_KW2 +: BITS_KW2] == '0);
    assign w_first_cnt = w_kw2_zero ? CNT_W'(CFG_BEATS_1X1 - 1) : CNT_W'(CFG_BEATS_3X3 - 1);
    // True when the beat on the config port would be the last of its block.
    assign w_nth_beat  = (r_state == StCfgFirst) ? (w_first_cnt == '0) : (r_cnt == CNT_W'(1));

    // Select the beat entering the skid buffer; config beats never carry tlast downstream.
    always_comb begin
        w_in_data = s_dat_tdata;
        w_in_user = s_dat_tuser;
        w_in_last = s_dat_tlast;
        if (w_cfg_phase) begin
            w_in_data = s_cfg_tdata;
            w_in_user = s_cfg_tuser;
            w_in_last = 1'b0;
        end
    end

    // Framing FSM next state, beat counter, framing error and iteration count.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_cfg_error_next = r_cfg_error;
        w_iter_next      = r_iter;
        if (w_cfg_hs && (s_cfg_tlast != w_nth_beat)) begin
            w_cfg_error_next = 1'b1;
        end
        unique case (r_state)
            StCfgFirst: begin
                if (w_cfg_hs) begin
                    w_cnt_next   = w_first_cnt;
                    w_state_next = w_nth_beat ? StPass : StCfgRest;
                end
            end
            StCfgRest: begin
                if (w_cfg_hs) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                    if (w_nth_beat) begin
                        w_state_next = StPass;
                    end
                end
            end
            StPass: begin
                if (w_dat_hs && s_dat_tlast) begin
                    w_state_next = StCfgFirst;
                    w_iter_next  = r_iter + 16'd1;
                end
            end
            default: begin
                w_state_next = StCfgFirst;
            end
        endcase
    end

    // FSM and status registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= StCfgFirst;
            r_cnt       <= '0;
            r_cfg_error <= 1'b0;
            r_iter      <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_cfg_error <= w_cfg_error_next;
            r_iter      <= w_iter_next;
        end
    end

    // Skid buffer occupancy and entry storage.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_count     <= 2'd0;
            r_head_data <= '0;
            r_head_user <= '0;
            r_head_last <= 1'b0;
            r_skid_data <= '0;
            r_skid_user <= '0;
            r_skid_last <= 1'b0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head_data <= r_skid_data;
                    r_head_user <= r_skid_user;
                    r_head_last <= r_skid_last;
                end else if (w_push) begin
                    r_head_data <= w_in_data;
                    r_head_user <= w_in_user;
                    r_head_last <= w_in_last;
                end
            end else if (w_push && (r_count == 2'd0)) begin
                r_head_data <= w_in_data;
                r_head_user <= w_in_user;
                r_head_last <= w_in_last;
            end
            if (w_push && (((r_count == 2'd2) && w_pop) || ((r_count == 2'd1) && !w_pop))) begin
                r_skid_data <= w_in_data;
                r_skid_user <= w_in_user;
                r_skid_last <= w_in_last;
            end
        end
    end

    assign m_axis_tvalid = (r_count != 2'd0);
    assign m_axis_tdata  = r_head_data;
    assign m_axis_tuser  = r_head_user;
    assign m_axis_tlast  = r_head_last;
    assign cfg_error     = r_cfg_error;
    assign debug_state   = r_state;
    assign iter_count    = r_iter;

endmodule

// File: tb/tb_axis_lrelu_config_injector.sv
// Directed bench for axis_lrelu_config_injector.
module tb_axis_lrelu_config_injector;

    logic         aclk;
    logic         areset;
    logic         s_cfg_tvalid, s_cfg_tready, s_cfg_tlast;
    logic [255:0] s_cfg_tdata;
    logic [7:0]   s_cfg_tuser;
    logic         s_dat_tvalid, s_dat_tready, s_dat_tlast;
    logic [255:0] s_dat_tdata;
    logic [7:0]   s_dat_tuser;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [7:0]   m_axis_tuser;
    logic         cfg_error;
    logic [1:0]   debug_state;
    logic [15:0]  iter_count;

    typedef struct {
        logic [255:0] data;
        logic [7:0]   user;
        logic         last;
        int           cyc;
    } beat_t;

    beat_t cfg_q[$];
    beat_t dat_q[$];
    beat_t exp_q[$];
    beat_t out_q[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   cfg_hs_cnt = 0;
    int   cfg_first_cyc = -1;
    int   cfg_at_dat = -1;
    logic dat_seen = 1'b0;
    logic cfg_acc = 1'b0;
    logic dat_acc = 1'b0;
    logic rand_ready = 1'b0;
    logic ready_val = 1'b1;

    axis_lrelu_config_injector dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_cfg_tvalid  (s_cfg_tvalid),
        .s_cfg_tready  (s_cfg_tready),
        .s_cfg_tdata   (s_cfg_tdata),
        .s_cfg_tuser   (s_cfg_tuser),
        .s_cfg_tlast   (s_cfg_tlast),
        .s_dat_tvalid  (s_dat_tvalid),
        .s_dat_tready  (s_dat_tready),
        .s_dat_tdata   (s_dat_tdata),
        .s_dat_tuser   (s_dat_tuser),
        .s_dat_tlast   (s_dat_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .cfg_error     (cfg_error),
        .debug_state   (debug_state),
        .iter_count    (iter_count)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    // Monitor: records handshakes at the falling edge, ahead of the edge that completes them.
    initial begin
        forever begin
            @(negedge aclk);
            cfg_acc = s_cfg_tvalid && s_cfg_tready;
            dat_acc = s_dat_tvalid && s_dat_tready;
            if (cfg_acc) begin
                if (cfg_hs_cnt == 0) cfg_first_cyc = cyc;
                cfg_hs_cnt++;
            end
            if (dat_acc && !dat_seen) begin
                dat_seen   = 1'b1;
                cfg_at_dat = cfg_hs_cnt;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_q.push_back('{m_axis_tdata, m_axis_tuser, m_axis_tlast, cyc});
            end
        end
    end

    // Source driver: presents the head of each input queue, advancing after a handshake.
    initial begin
        s_cfg_tvalid = 1'b0; s_cfg_tdata = '0; s_cfg_tuser = '0; s_cfg_tlast = 1'b0;
        s_dat_tvalid = 1'b0; s_dat_tdata = '0; s_dat_tuser = '0; s_dat_tlast = 1'b0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (cfg_acc && cfg_q.size() > 0) void'(cfg_q.pop_front());
            if (dat_acc && dat_q.size() > 0) void'(dat_q.pop_front());
            if (cfg_q.size() > 0) begin
                s_cfg_tvalid = 1'b1;
                s_cfg_tdata  = cfg_q[0].data;
                s_cfg_tuser  = cfg_q[0].user;
                s_cfg_tlast  = cfg_q[0].last;
            end else begin
                s_cfg_tvalid = 1'b0;
            end
            if (dat_q.size() > 0) begin
                s_dat_tvalid = 1'b1;
                s_dat_tdata  = dat_q[0].data;
                s_dat_tuser  = dat_q[0].user;
                s_dat_tlast  = dat_q[0].last;
            end else begin
                s_dat_tvalid = 1'b0;
            end
            if (rand_ready) m_axis_tready = ($urandom_range(0, 1) == 1);
            else            m_axis_tready = ready_val;
        end
    end

    task automatic do_reset();
        @(posedge aclk);
        #3;
        areset = 1'b1;
        cfg_q.delete();
        dat_q.delete();
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #3;
        areset        = 1'b0;
        out_q.delete();
        cfg_hs_cnt    = 0;
        cfg_first_cyc = -1;
        cfg_at_dat    = -1;
        dat_seen      = 1'b0;
    endtask

    // Queues one iteration and its expected output; extra_last adds a stray cfg tlast.
    task automatic push_iter(input logic [2:0] kw2, input int ncfg, input int ndat,
                             input logic [7:0] cbase, input logic [7:0] dbase,
                             input int extra_last);
        beat_t b;
        for (int i = 0; i < ncfg; i++) begin
            b.data          = '0;
            b.data[7:0]     = cbase + 8'(i);
            b.data[255:248] = 8'hCC;
            b.user          = (i == 0) ? {5'b0, kw2} : 8'h40 + 8'(i);
            b.last          = (i == ncfg - 1) || (i == extra_last);
            b.cyc           = 0;
            cfg_q.push_back(b);
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < ndat; i++) begin
            b.data          = '0;
            b.data[7:0]     = dbase + 8'(i);
            b.data[255:248] = 8'hDD;
            b.user          = 8'h80 + 8'(i);
            b.last          = (i == ndat - 1);
            b.cyc           = 0;
            dat_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_outs(input int n);
        for (int i = 0; i < 400 && out_q.size() < n; i++) begin
            @(negedge aclk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 ||
            m_axis_tuser !== '0) begin
            failures++;
            $display("FAIL reset_out: got v=%b l=%b d=%h u=%h, expected all zero",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser);
        end
        checks++;
        if (cfg_error !== 1'b0 || iter_count !== 16'd0 || debug_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_status: got err=%b iter=%0d st=%0d, expected 0/0/0",
                     cfg_error, iter_count, debug_state);
        end
        checks++;
        if (s_cfg_tready !== 1'b0 || s_dat_tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got cfg=%b dat=%b, expected 0/0",
                     s_cfg_tready, s_dat_tready);
        end
        @(posedge aclk);
        #3;
        areset = 1'b0;
        @(negedge aclk);
        #1;
        checks++;
        if (s_cfg_tready !== 1'b1 || s_dat_tready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: got cfg=%b dat=%b, expected 1/0",
                     s_cfg_tready, s_dat_tready);
        end
    endtask

    task automatic test_basic_1x1();
        do_reset();
        ready_val = 1'b1;
        push_iter(3'd0, 2, 4, 8'hC0, 8'hD0, -1);
        wait_outs(6);
        checks++;
        if (out_q.size() != 6) begin
            failures++;
            $display("FAIL t1_count: got %0d beats, expected 6", out_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i].data !== exp_q[i].data || out_q[i].user !== exp_q[i].user ||
                out_q[i].last !== exp_q[i].last ||
                out_q[i].cyc != cfg_first_cyc + 1 + i) begin
                failures++;
                $display("FAIL t1_beat%0d: got d=%h u=%h l=%b cyc=%0d, expected d=%h u=%h l=%b cyc=%0d",
                         i, out_q[i].data, out_q[i].user, out_q[i].last, out_q[i].cyc,
                         exp_q[i].data, exp_q[i].user, exp_q[i].last, cfg_first_cyc + 1 + i);
            end
        end
        @(negedge aclk);
        #1;
        checks++;
        if (iter_count !== 16'd1 || debug_state !== 2'd0 || cfg_error !== 1'b0) begin
            failures++;
            $display("FAIL t1_status: got iter=%0d st=%0d err=%b, expected 1/0/0",
                     iter_count, debug_state, cfg_error);
        end
    endtask

    task automatic test_cfg_3x3();
        do_reset();
        ready_val = 1'b1;
        push_iter(3'd3, 10, 2, 8'h10, 8'h50, -1);
        for (int i = 0; i < 50 && cfg_hs_cnt < 3; i++) begin
            @(negedge aclk);
            #1;
        end
        checks++;
        if (s_dat_tvalid !== 1'b1 || s_dat_tready !== 1'b0 || debug_state !== 2'd1) begin
            failures++;
            $display("FAIL t2_stall: got dvalid=%b dready=%b st=%0d, expected 1/0/1",
                     s_dat_tvalid, s_dat_tready, debug_state);
        end
        wait_outs(12);
        checks++;
        if (cfg_at_dat != 10 || out_q.size() != 12) begin
            failures++;
            $display("FAIL t2_cfg_before_data: got cfg=%0d beats=%0d, expected 10/12",
                     cfg_at_dat, out_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i].data !== exp_q[i].data || out_q[i].user !== exp_q[i].user ||
                out_q[i].last !== exp_q[i].last) begin
                failures++;
                $display("FAIL t2_beat%0d: got d=%h u=%h l=%b, expected d=%h u=%h l=%b",
                         i, out_q[i].data, out_q[i].user, out_q[i].last,
                         exp_q[i].data, exp_q[i].user, exp_q[i].last);
            end
        end
    endtask

    task automatic test_random_stall();
        logic         prev_stall;
        logic [255:0] pd;
        logic [7:0]   pu;
        logic         pl;
        do_reset();
        rand_ready = 1'b1;
        push_iter(3'd0, 2, 3, 8'h20, 8'h60, -1);
        push_iter(3'd1, 10, 2, 8'h30, 8'h70, -1);
        push_iter(3'd0, 2, 1, 8'h40, 8'h78, -1);
        prev_stall = 1'b0;
        pd = '0; pu = '0; pl = 1'b0;
        for (int i = 0; i < 600 && out_q.size() < 20; i++) begin
            @(negedge aclk);
            #1;
            if (prev_stall) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tuser !== pu ||
                    m_axis_tlast !== pl) begin
                    failures++;
                    $display("FAIL t3_hold: got v=%b d=%h, expected v=1 d=%h",
                             m_axis_tvalid, m_axis_tdata, pd);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pu = m_axis_tuser;
            pl = m_axis_tlast;
        end
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        checks++;
        if (out_q.size() != 20) begin
            failures++;
            $display("FAIL t3_count: got %0d beats, expected 20", out_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i].data !== exp_q[i].data || out_q[i].user !== exp_q[i].user ||
                out_q[i].last !== exp_q[i].last) begin
                failures++;
                $display("FAIL t3_beat%0d: got d=%h u=%h l=%b, expected d=%h u=%h l=%b",
                         i, out_q[i].data, out_q[i].user, out_q[i].last,
                         exp_q[i].data, exp_q[i].user, exp_q[i].last);
            end
        end
        @(negedge aclk);
        #1;
        checks++;
        if (iter_count !== 16'd3 || cfg_error !== 1'b0) begin
            failures++;
            $display("FAIL t3_status: got iter=%0d err=%b, expected 3/0", iter_count, cfg_error);
        end
    endtask

    task automatic test_framing_error();
        do_reset();
        ready_val = 1'b1;
        push_iter(3'd3, 10, 2, 8'hA0, 8'hB0, 1);
        for (int i = 0; i < 50 && cfg_hs_cnt < 3; i++) begin
            @(negedge aclk);
            #1;
        end
        checks++;
        if (cfg_error !== 1'b1) begin
            failures++;
            $display("FAIL t4_err_set: got %b, expected 1", cfg_error);
        end
        wait_outs(12);
        checks++;
        if (cfg_at_dat != 10 || out_q.size() != 12) begin
            failures++;
            $display("FAIL t4_framing: got cfg=%0d beats=%0d, expected 10/12",
                     cfg_at_dat, out_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last) begin
                failures++;
                $display("FAIL t4_beat%0d: got d=%h l=%b, expected d=%h l=%b",
                         i, out_q[i].data, out_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        @(negedge aclk);
        #1;
        checks++;
        if (cfg_error !== 1'b1 || iter_count !== 16'd1) begin
            failures++;
            $display("FAIL t4_sticky: got err=%b iter=%0d, expected 1/1", cfg_error, iter_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready_val = 1'b1;
        push_iter(3'd0, 2, 1, 8'hE0, 8'hF0, -1);
        push_iter(3'd0, 2, 1, 8'hE4, 8'hF4, -1);
        wait_outs(6);
        checks++;
        if (out_q.size() != 6) begin
            failures++;
            $display("FAIL t5_count: got %0d beats, expected 6", out_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last ||
                out_q[i].cyc != cfg_first_cyc + 1 + i) begin
                failures++;
                $display("FAIL t5_beat%0d: got d=%h l=%b cyc=%0d, expected d=%h l=%b cyc=%0d",
                         i, out_q[i].data, out_q[i].last, out_q[i].cyc,
                         exp_q[i].data, exp_q[i].last, cfg_first_cyc + 1 + i);
            end
        end
        @(negedge aclk);
        #1;
        checks++;
        if (iter_count !== 16'd2) begin
            failures++;
            $display("FAIL t5_iter: got %0d, expected 2", iter_count);
        end
    endtask

    task automatic test_reset_in_pass();
        do_reset();
        ready_val = 1'b0;
        push_iter(3'd0, 2, 4, 8'h90, 8'h98, 0);
        for (int i = 0; i < 50 && debug_state !== 2'd2; i++) begin
            @(negedge aclk);
            #1;
        end
        @(negedge aclk);
        #1;
        checks++;
        if (debug_state !== 2'd2 || m_axis_tvalid !== 1'b1 || s_dat_tready !== 1'b0 ||
            cfg_error !== 1'b1 || m_axis_tdata[7:0] !== 8'h90) begin
            failures++;
            $display("FAIL t6_pre: got st=%0d v=%b dready=%b err=%b d=%h, expected 2/1/0/1/90",
                     debug_state, m_axis_tvalid, s_dat_tready, cfg_error, m_axis_tdata[7:0]);
        end
        @(posedge aclk);
        #3;
        areset = 1'b1;
        cfg_q.delete();
        dat_q.delete();
        @(negedge aclk);
        #1;
        checks++;
        if (s_cfg_tready !== 1'b0 || s_dat_tready !== 1'b0) begin
            failures++;
            $display("FAIL t6_ready_in_reset: got cfg=%b dat=%b, expected 0/0",
                     s_cfg_tready, s_dat_tready);
        end
        @(negedge aclk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || debug_state !== 2'd0 || iter_count !== 16'd0 ||
            cfg_error !== 1'b0) begin
            failures++;
            $display("FAIL t6_post: got v=%b st=%0d iter=%0d err=%b, expected 0/0/0/0",
                     m_axis_tvalid, debug_state, iter_count, cfg_error);
        end
        ready_val = 1'b1;
        do_reset();
    endtask

    initial begin
        areset = 1'b1;
        test_reset();
        test_basic_1x1();
        test_cfg_3x3();
        test_random_stall();
        test_framing_error();
        test_back_to_back();
        test_reset_in_pass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
